// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
//   EX-stage partner of the gshare predictor. Each IF-stage prediction
//   (taken, target) rides alongside its instruction through ID and EX in
//   shadow registers. When the instruction reaches EX as a branch, it is
//   compared against the resolved outcome. The predictor gets an update
//   strobe with the real direction. A wrong prediction starts a RUN/RECOVER
//   sequence that squashes younger instructions and redirects fetch.
//
// Ports
//   clk             clock; all state on rising edge
//   reset           asynchronous, active-high; clears all state
//   Hazard          pipeline stall; freezes the IF->ID->EX shadow advance
//   if_valid        IF holds a real instruction this cycle
//   if_pc           PC of the IF instruction
//   if_pred_taken   predictor's taken output for if_pc
//   if_pred_target  predicted target, meaningful when taken
//   ex_is_branch    EX instruction is a conditional branch
//   ex_real_taken   resolved direction in EX
//   ex_real_target  resolved taken target in EX
//   update          predictor update strobe (combinational)
//   real_taken      resolved direction to predictor (combinational)
//   flush           squash IF/ID/EX younger instructions (registered)
//   redirect_valid  one-cycle pulse: load redirect_pc into PC (registered)
//   redirect_pc     correct fetch PC (registered)
//   br_count        resolved-branch counter, saturating (BRRES_PERF_EN only)
//   mis_count       mispredict counter, saturating (BRRES_PERF_EN only)
//
// Configuration
//   BRRES_PERF_EN   when defined, adds the br_count / mis_count outputs.
// -----------------------------------------------------------------------------
module branch_resolver #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Hazard,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic            if_pred_taken,
    input  logic [XLEN-1:0] if_pred_target,
    input  logic            ex_is_branch,
    input  logic            ex_real_taken,
    input  logic [XLEN-1:0] ex_real_target,
    output logic            update,
    output logic            real_taken,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
`ifdef BRRES_PERF_EN
    ,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mis_count
`endif
);

    // Elaboration-time guards on the configuration.
    if (FLUSH_CYCLES < 1) begin : g_bad_flush
        $error("branch_resolver: FLUSH_CYCLES must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("branch_resolver: CNT_W must be >= 1");
    end

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic            pred_taken;
        logic [XLEN-1:0] pred_target;
    } shadow_t;

    state_t          state;
    shadow_t         id_q;
    shadow_t         ex_q;
    logic [FC_W-1:0] flush_cnt;
    logic            fire;
    logic            mis;
    logic [XLEN-1:0] fix_pc;

    // Resolve: compare the EX shadow prediction with the real outcome.
    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // override, so no path through the block can infer a latch.
        fix_pc = ex_q.pc + XLEN'(4);   // not-taken fall-through, wraps
        if (ex_real_taken) begin
            fix_pc = ex_real_target;
        end
        fire = ex_q.valid & ex_is_branch & ~Hazard & (state == RUN);
        mis  = fire & ((ex_q.pred_taken != ex_real_taken) |
                       (ex_real_taken & (ex_q.pred_target != ex_real_target)));
    end

    assign update     = fire;
    assign real_taken = ex_real_taken;

    // Shadow pipe: prediction metadata follows its instruction to EX.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments throughout; the later valid clear
        // below deliberately wins over the advance in the same cycle.
        if (reset) begin
            id_q <= '0;
            ex_q <= '0;
        end else begin
            if (!Hazard) begin
                id_q <= '{valid:       if_valid,
                          pc:          if_pc,
                          pred_taken:  if_pred_taken,
                          pred_target: if_pred_target};
                ex_q <= id_q;
            end
            // Squashed instructions must never resolve, stall or not.
            if (flush) begin
                id_q.valid <= 1'b0;
                ex_q.valid <= 1'b0;
            end
        end
    end

    // Recovery FSM. flush is raised the cycle after the mispredict and held
    // for FLUSH_CYCLES cycles; Hazard has no effect on the countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= RUN;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush_cnt      <= '0;
        end else begin
            redirect_valid <= 1'b0;
            case (state)
                RUN: begin
                    if (mis) begin
                        state          <= RECOVER;
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= fix_pc;
                        flush_cnt      <= FC_W'(FLUSH_CYCLES - 1);
                    end
                end
                RECOVER: begin
                    if (flush_cnt == '0) begin
                        state <= RUN;
                        flush <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - FC_W'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef BRRES_PERF_EN
    // Saturating performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_count  <= '0;
            mis_count <= '0;
        end else begin
            if (fire && (br_count != '1)) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (mis && (mis_count != '1)) begin
                mis_count <= mis_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// -----------------------------------------------------------------------------
// tb_branch_resolver
//   Directed-vector bench for branch_resolver with hand-computed expectations.
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   1-2 time units after the edge, clear of the active clock edge.
// -----------------------------------------------------------------------------
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        reset;
    logic        Hazard;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_is_branch;
    logic        ex_real_taken;
    logic [31:0] ex_real_target;
    logic        update;
    logic        real_taken;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef BRRES_PERF_EN
    logic [31:0] br_count;
    logic [31:0] mis_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_resolver #(
        .XLEN(32),
        .FLUSH_CYCLES(2),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Hazard(Hazard),
        .if_valid(if_valid),
        .if_pc(if_pc),
        .if_pred_taken(if_pred_taken),
        .if_pred_target(if_pred_target),
        .ex_is_branch(ex_is_branch),
        .ex_real_taken(ex_real_taken),
        .ex_real_target(ex_real_target),
        .update(update),
        .real_taken(real_taken),
        .flush(flush),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
`ifdef BRRES_PERF_EN
        ,
        .br_count(br_count),
        .mis_count(mis_count)
`endif
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one valid instruction through IF and ID; on return it is in EX.
    task automatic feed(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        if_valid       = 1'b1;
        if_pc          = pc;
        if_pred_taken  = pt;
        if_pred_target = tgt;
        tick();
        if_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; Hazard = 1'b0; if_valid = 1'b0; if_pc = '0;
        if_pred_taken = 1'b0; if_pred_target = '0;
        ex_is_branch = 1'b0; ex_real_taken = 1'b0; ex_real_target = '0;
        #3 reset = 1'b1;
        #1;
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", flush); end
        total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL reset_rv got=%b exp=0", redirect_valid); end
        total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_rpc got=%h exp=0", redirect_pc); end
        total++; if (update !== 1'b0) begin bad++; $display("FAIL reset_update got=%b exp=0", update); end
`ifdef BRRES_PERF_EN
        total++; if (br_count !== 32'h0 || mis_count !== 32'h0) begin
            bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", br_count, mis_count); end
`endif
        tick();
        tick();
        reset = 1'b0;
        // Shadows invalid: a branch flag in EX must not resolve.
        ex_is_branch = 1'b1;
        #1;
        total++; if (update !== 1'b0) begin bad++; $display("FAIL reset_shadow_ex got=%b exp=0", update); end
        tick();
        total++; if (update !== 1'b0) begin bad++; $display("FAIL reset_shadow_id got=%b exp=0", update); end
        ex_is_branch = 1'b0;
    endtask

    task automatic test_correct_taken();
        feed(32'h100, 1'b1, 32'h180);
        ex_is_branch = 1'b1; ex_real_taken = 1'b1; ex_real_target = 32'h180;
        #1;
        total++; if (update !== 1'b1) begin bad++; $display("FAIL ok_update got=%b exp=1", update); end
        total++; if (real_taken !== 1'b1) begin bad++; $display("FAIL ok_real_taken got=%b exp=1", real_taken); end
        tick();
        total++; if (update !== 1'b0) begin bad++; $display("FAIL ok_single_update got=%b exp=0", update); end
        total++; if (flush !== 1'b0 || redirect_valid !== 1'b0) begin
            bad++; $display("FAIL ok_no_recover got=%b%b exp=00", flush, redirect_valid); end
        ex_is_branch = 1'b0;
        tick();
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL ok_no_flush got=%b exp=0", flush); end
    endtask

    task automatic test_mispredict_not_taken();
        // Branch A, then a younger mispredicting branch B right behind it.
        if_valid = 1'b1; if_pc = 32'h200; if_pred_taken = 1'b1; if_pred_target = 32'h280;
        tick();
        if_pc = 32'h204; if_pred_taken = 1'b1; if_pred_target = 32'h999;
        tick();
        if_valid = 1'b0;
        ex_is_branch = 1'b1; ex_real_taken = 1'b0; ex_real_target = 32'h0;
        #1;
        total++; if (update !== 1'b1 || real_taken !== 1'b0) begin
            bad++; $display("FAIL nt_update got=%b/%b exp=1/0", update, real_taken); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL nt_flush_early got=%b exp=0", flush); end
        tick();
        total++; if (update !== 1'b0) begin bad++; $display("FAIL nt_recover_update got=%b exp=0", update); end
        total++; if (flush !== 1'b1 || redirect_valid !== 1'b1) begin
            bad++; $display("FAIL nt_recover1 got=%b%b exp=11", flush, redirect_valid); end
        total++; if (redirect_pc !== 32'h204) begin bad++; $display("FAIL nt_rpc got=%h exp=00000204", redirect_pc); end
        tick();
        total++; if (flush !== 1'b1 || redirect_valid !== 1'b0) begin
            bad++; $display("FAIL nt_recover2 got=%b%b exp=10", flush, redirect_valid); end
        total++; if (update !== 1'b0) begin bad++; $display("FAIL nt_recover2_update got=%b exp=0", update); end
        tick();
        total++; if (flush !== 1'b0 || redirect_valid !== 1'b0) begin
            bad++; $display("FAIL nt_run got=%b%b exp=00", flush, redirect_valid); end
        total++; if (update !== 1'b0) begin bad++; $display("FAIL nt_squashed got=%b exp=0", update); end
        ex_is_branch = 1'b0;
    endtask

    task automatic test_wrong_target();
        feed(32'h2F0, 1'b1, 32'h340);
        ex_is_branch = 1'b1; ex_real_taken = 1'b1; ex_real_target = 32'h300;
        #1;
        total++; if (update !== 1'b1) begin bad++; $display("FAIL tgt_update got=%b exp=1", update); end
        tick();
        ex_is_branch = 1'b0;
        Hazard = 1'b1;   // stall during recovery must not stretch it
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h300) begin
            bad++; $display("FAIL tgt_rpc got=%b/%h exp=1/00000300", redirect_valid, redirect_pc); end
        tick();
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL tgt_flush2 got=%b exp=1", flush); end
        tick();
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL tgt_hazard_ext got=%b exp=0", flush); end
        Hazard = 1'b0;
    endtask

    task automatic test_pc_wrap();
        feed(32'hFFFF_FFFC, 1'b1, 32'h10);
        ex_is_branch = 1'b1; ex_real_taken = 1'b0; ex_real_target = 32'h10;
        #1;
        total++; if (update !== 1'b1) begin bad++; $display("FAIL wrap_update got=%b exp=1", update); end
        tick();
        ex_is_branch = 1'b0;
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0) begin
            bad++; $display("FAIL wrap_rpc got=%b/%h exp=1/00000000", redirect_valid, redirect_pc); end
        tick();
        tick();
    endtask

    task automatic test_hazard();
        feed(32'h500, 1'b0, 32'h0);
        Hazard = 1'b1;
        ex_is_branch = 1'b1; ex_real_taken = 1'b1; ex_real_target = 32'h600;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (update !== 1'b0 || flush !== 1'b0) begin
                bad++; $display("FAIL hz_stall%0d got=%b%b exp=00", i, update, flush); end
            tick();
        end
        Hazard = 1'b0;
        #1;
        total++; if (update !== 1'b1 || real_taken !== 1'b1) begin
            bad++; $display("FAIL hz_release got=%b/%b exp=1/1", update, real_taken); end
        tick();
        total++; if (update !== 1'b0) begin bad++; $display("FAIL hz_single got=%b exp=0", update); end
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h600 || flush !== 1'b1) begin
            bad++; $display("FAIL hz_redirect got=%b/%h/%b exp=1/00000600/1", redirect_valid, redirect_pc, flush); end
        ex_is_branch = 1'b0;
        tick();
        tick();
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL hz_end got=%b exp=0", flush); end
`ifdef BRRES_PERF_EN
        total++; if (br_count !== 32'd5 || mis_count !== 32'd4) begin
            bad++; $display("FAIL perf_counts got=%0d/%0d exp=5/4", br_count, mis_count); end
`endif
    endtask

    task automatic test_non_branch();
        feed(32'h700, 1'b1, 32'h900);
        ex_is_branch = 1'b0; ex_real_taken = 1'b1; ex_real_target = 32'h123;
        #1;
        total++; if (update !== 1'b0) begin bad++; $display("FAIL nb_update got=%b exp=0", update); end
        tick();
        total++; if (flush !== 1'b0 || redirect_valid !== 1'b0) begin
            bad++; $display("FAIL nb_recover got=%b%b exp=00", flush, redirect_valid); end
    endtask

    task automatic test_reset_mid_recover();
        feed(32'h800, 1'b0, 32'h0);
        ex_is_branch = 1'b1; ex_real_taken = 1'b1; ex_real_target = 32'h880;
        tick();
        total++; if (flush !== 1'b1 || redirect_pc !== 32'h880) begin
            bad++; $display("FAIL rr_pre got=%b/%h exp=1/00000880", flush, redirect_pc); end
        #2 reset = 1'b1;
        #1;
        total++; if (flush !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
            bad++; $display("FAIL rr_abort got=%b/%b/%h exp=0/0/00000000", flush, redirect_valid, redirect_pc); end
        tick();
        reset = 1'b0;
        ex_is_branch = 1'b0;
        feed(32'h900, 1'b0, 32'h0);
        ex_is_branch = 1'b1; ex_real_taken = 1'b0; ex_real_target = 32'h0;
        #1;
        total++; if (update !== 1'b1) begin bad++; $display("FAIL rr_run_update got=%b exp=1", update); end
        tick();
        ex_is_branch = 1'b0;
        total++; if (flush !== 1'b0 || redirect_valid !== 1'b0) begin
            bad++; $display("FAIL rr_run got=%b%b exp=00", flush, redirect_valid); end
`ifdef BRRES_PERF_EN
        total++; if (br_count !== 32'd1 || mis_count !== 32'd0) begin
            bad++; $display("FAIL rr_perf got=%0d/%0d exp=1/0", br_count, mis_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_correct_taken();
        test_mispredict_not_taken();
        test_wrong_target();
        test_pc_wrap();
        test_hazard();
        test_non_branch();
        test_reset_mid_recover();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
